// File: rtl/conv2d_pkg.sv
// conv2d_pkg: shared conv2D constants, streamer state encoding and element-slice helper
package conv2d_pkg;
  localparam int DATA_W_DEF = 14;
  localparam int DEPTH_DEF = 432;
  localparam int F_BIT_DEF = 7;
  typedef enum logic {IDLE, STREAM} state_t;
  function automatic int elem_lsb(input int idx, input int w);
    return idx * w;
  endfunction
endpackage

// File: rtl/p2s_shift_reg.sv
// p2s_shift_reg: parallel-load register emptied one element per shift, low element first
module p2s_shift_reg import conv2d_pkg::*; #(
  parameter int W = DATA_W_DEF,
  parameter int N = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         load,
  input  logic         shift,
  input  logic [W*N-1:0] d,
  output logic [W-1:0] q
);
  logic [W*N-1:0] r;
  always_ff @(posedge clk)
    if (rst || clr) r <= '0;
    else if (load) r <= d;
    else if (shift) r <= r >> W;
  assign q = r[elem_lsb(0, W) +: W];
endmodule

// File: rtl/conv2d_p2s_streamer.sv
// conv2d_p2s_streamer: unloads a packed DEPTH-element vector one element per beat; P2S_BACK_TO_BACK_EN enables bubble-free reload
module conv2d_p2s_streamer import conv2d_pkg::*; #(
  parameter int DATA_Width = DATA_W_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int f_bit = F_BIT_DEF,
  localparam int CNT_W = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [DATA_Width*DEPTH-1:0] data_in,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_Width-1:0]       data_out,
  output logic                        out_last,
  output logic [CNT_W-1:0]            out_idx,
  output logic                        busy
);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);
  if (DEPTH < 1 || f_bit < 0 || f_bit >= DATA_Width) begin : g_bad_cfg
    $error("conv2d_p2s_streamer: bad DEPTH/f_bit");
  end
  state_t state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic beat, last, load, b2b;
  assign last = state == STREAM && cnt == LAST_IDX;
  assign beat = state == STREAM && out_ready;
`ifdef P2S_BACK_TO_BACK_EN
  assign b2b = last && out_ready;
`else
  assign b2b = 1'b0;
`endif
  always_comb begin
    load_ready = !rst && !flush && (state == IDLE || b2b);
    load = load_valid && load_ready;
    state_n = flush ? IDLE : load ? STREAM : (beat && last) ? IDLE : state;
    cnt_n = (flush || load || (beat && last)) ? '0 : beat ? cnt + 1'b1 : cnt;
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  p2s_shift_reg #(.W(DATA_Width), .N(DEPTH)) u_sr (
    .clk(clk), .rst(rst), .clr(flush), .load(load), .shift(beat),
    .d(data_in), .q(data_out)
  );
  assign out_valid = state == STREAM;
  assign busy = state == STREAM;
  assign out_last = last;
  assign out_idx = cnt;
  a_cnt_range: assert property (@(posedge clk) disable iff (rst) cnt <= LAST_IDX);
endmodule

// File: tb/tb_conv2d_p2s_streamer.sv
// tb_conv2d_p2s_streamer: randomized scoreboard bench for a DEPTH=4 instance plus a DEPTH=432 ramp run
module tb_conv2d_p2s_streamer;
  localparam int W = 14, N = 4, NB = 432;
`ifdef P2S_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic lv = 0, lr, fl = 0, ov, ordy = 0, ol, bz;
  logic [W*N-1:0] din = '0;
  logic [W-1:0] dout;
  logic [1:0] oidx;
  logic lv2 = 0, lr2, fl2 = 0, ov2, ordy2 = 1, ol2, bz2;
  logic [W*NB-1:0] din2 = '0;
  logic [W-1:0] dout2;
  logic [8:0] oidx2;
  conv2d_p2s_streamer #(.DATA_Width(W), .DEPTH(N), .f_bit(7)) dut (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(lr), .data_in(din), .flush(fl),
    .out_valid(ov), .out_ready(ordy), .data_out(dout), .out_last(ol), .out_idx(oidx), .busy(bz)
  );
  conv2d_p2s_streamer dut_big (
    .clk(clk), .rst(rst), .load_valid(lv2), .load_ready(lr2), .data_in(din2), .flush(fl2),
    .out_valid(ov2), .out_ready(ordy2), .data_out(dout2), .out_last(ol2), .out_idx(oidx2), .busy(bz2)
  );
  typedef struct {logic [W-1:0] d; int idx; bit last;} elem_t;
  elem_t q[$];
  int n_cmp = 0, n_err = 0;
  int k2 = 0, gaps = 0, cyc = 0, last_cyc = 0;
  function automatic void chk(string nm, logic [63:0] a, logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endfunction
  task automatic cycle(input bit v, input logic [W*N-1:0] vec, input bit r, input bit f, input bit rs);
    @(posedge clk);
    #1 lv = v; din = vec; ordy = r; fl = f; rst = rs;
    #1;
    chk("load_ready", 64'(lr), 64'(!rs && !f && (q.size() == 0 || (B2B && q.size() == 1 && r))));
    chk("out_valid", 64'(ov), 64'(q.size() != 0));
    if (q.size() == 0) chk("idle_outs", 64'({dout, oidx, ol, bz}), 64'(0));
    if (rs || f) q.delete();
    else if (v && lr)
      for (int i = 0; i < N; i++) q.push_back('{vec[i*W +: W], i, i == N - 1});
  endtask
  task automatic drain(input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, 1, 0, 0);
  endtask
  always @(negedge clk)
    if (!rst && !fl && ov) begin
      if (q.size() == 0) chk("unexpected_beat", 64'(ov), 64'(0));
      else begin
        chk("data_out", 64'(dout), 64'(q[0].d));
        chk("out_idx", 64'(oidx), 64'(q[0].idx));
        chk("out_last", 64'(ol), 64'(q[0].last));
        if (ordy) void'(q.pop_front());
      end
    end
  always @(posedge clk) cyc++;
  always @(negedge clk)
    if (!rst && ov2 && ordy2) begin
      chk("ramp_data", 64'(dout2), 64'(k2 % NB));
      chk("ramp_idx", 64'(oidx2), 64'(k2 % NB));
      chk("ramp_last", 64'(ol2), 64'((k2 % NB) == NB - 1));
      if (k2 > 0 && cyc - last_cyc != 1) gaps++;
      last_cyc = cyc;
      k2++;
    end
  initial begin
    logic [W*N-1:0] v1, v2, rv;
    int n_load2, c;
    v1 = {14'd4, 14'd3, 14'd2, 14'd1};
    v2 = {14'h3aa, 14'h155, 14'h2f0, 14'h00f};
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
    cycle(1, v1, 1, 0, 0);
    drain(6);
    cycle(1, v1, 1, 0, 0);
    foreach (v2[i]) if (i < 7) cycle(0, '0, (7'b1011001 >> (6 - i)) & 1'b1, 0, 0);
    drain(4);
    cycle(1, v1, 1, 0, 0);
    for (int i = 0; i < 6; i++) cycle(1, v2, 1, 0, 0);
    drain(8);
    cycle(1, v1, 1, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(0, '0, 1, 1, 0);
    cycle(0, '0, 1, 0, 0);
    cycle(1, v2, 0, 0, 0);
    drain(6);
    cycle(1, v2, 0, 0, 0);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
    cycle(0, '0, 1, 0, 0);
    for (int t = 0; t < 400; t++) begin
      for (int i = 0; i < N; i++) rv[i*W +: W] = W'($urandom);
      cycle($urandom_range(0, 2) != 0, rv, $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0, $urandom_range(0, 59) == 0);
    end
    drain(10);
    for (int i = 0; i < NB; i++) din2[i*W +: W] = W'(i);
    @(posedge clk);
    #1 lv2 = 1;
    #1 chk("big_load_ready", 64'(lr2), 64'(1));
    n_load2 = 1;
    @(posedge clk);
    #1 lv2 = 0;
    for (c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (!bz2) break;
      lv2 = B2B && n_load2 < 2 && lr2;
      if (lv2) n_load2++;
    end
    lv2 = 0;
    chk("big_done_in_time", 64'(c < 2000), 64'(1));
    chk("big_beats", 64'(k2), 64'(B2B ? 2 * NB : NB));
    chk("big_bubbles", 64'(gaps), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
